// File: rtl/instr_buffer_pkg.sv
// Shared types, entry layout and helpers for the frontend instruction buffer.
`ifndef ICACHE_FETCHWIDTH128_RANGE
`define ICACHE_FETCHWIDTH128_RANGE 127:0
`endif

package instr_buffer_pkg;

  localparam int IB_SLOTS     = 4;
  localparam int IB_ENTRY_W   = 129;
  localparam int IB_TGT_LSB   = 0;
  localparam int IB_TKN_BIT   = 32;
  localparam int IB_PC_LSB    = 33;
  localparam int IB_INSTR_LSB = 97;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  function automatic logic [IB_ENTRY_W-1:0] pack_entry(
    input logic [31:0] instr,
    input logic [63:0] pc,
    input logic        taken,
    input logic [31:0] target
  );
    return {instr, pc, taken, target};
  endfunction

endpackage

// File: rtl/instr_buffer_chk.sv
// Protocol checker: the fetch valid mask must be contiguous from slot 0.
module instr_buffer_chk (
  input logic       clock_i,
  input logic       reset_n_i,
  input logic [3:0] valid_i
);

  a_valid_contig: assert property (@(posedge clock_i) disable iff (!reset_n_i)
    ((valid_i & (valid_i + 4'd1)) == 4'd0));

endmodule

// File: rtl/instr_buffer_enq_ctrl.sv
// Enqueue control: slot count, per-slot write enables/indices and slot PCs.
module ib_enq_ctrl
  import instr_buffer_pkg::*;
#(
  parameter int PTR_W = 4
) (
  input  logic             fire_i,
  input  logic             skip0_i,
  input  logic [3:0]       valid_i,
  input  logic [PTR_W-1:0] wr_ptr_i,
  input  logic [63:0]      enq_pc_i,
  output logic [2:0]       n_wr_o,
  output logic [3:0]       we_o,
  output logic [PTR_W-1:0] widx_o [IB_SLOTS],
  output logic [63:0]      slot_pc_o [IB_SLOTS]
);

  logic [2:0] n_slots_s;

  // A bypassed slot 0 shifts the remaining slots down by one write position.
  always_comb begin
    n_slots_s = popcount4(valid_i);
    n_wr_o    = 3'd0;
    we_o      = 4'b0000;
    if (fire_i) begin
      n_wr_o = n_slots_s - {2'b00, skip0_i};
    end else begin
      n_wr_o = 3'd0;
    end
    for (int i = 0; i < IB_SLOTS; i++) begin
      slot_pc_o[i] = enq_pc_i + 64'(4 * i);
      widx_o[i]    = wr_ptr_i + PTR_W'(i) - PTR_W'(skip0_i);
      we_o[i]      = fire_i && (3'(i) < n_slots_s) && !(skip0_i && (i == 0));
    end
  end

endmodule

// File: rtl/instr_buffer.sv
// Frontend instruction buffer: 4-wide enqueue from fetch, 1-wide dequeue to decode.
// Optional same-cycle empty-buffer bypass of slot 0 when IB_BYPASS_EN is defined.
module instr_buffer
  import instr_buffer_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic [`ICACHE_FETCHWIDTH128_RANGE]  admin2ib_instr,
  input  logic [3:0]                          admin2ib_instr_valid,
  input  logic [3:0]                          admin2ib_predicttaken,
  input  logic [`ICACHE_FETCHWIDTH128_RANGE]  admin2ib_predicttarget,
  input  logic [63:0]                         ib_enq_pc,
  output logic                                ib2admin_ready,
  input  logic                                redirect_flush,
  output logic                                ib2dec_valid,
  input  logic                                dec2ib_ready,
  output logic [31:0]                         ib2dec_instr,
  output logic [63:0]                         ib2dec_pc,
  output logic                                ib2dec_predicttaken,
  output logic [31:0]                         ib2dec_predicttarget
);

  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]        count_q, count_d;
  logic                  ready_q;
  logic [IB_ENTRY_W-1:0] mem_q [DEPTH];

  logic                  enq_fire_s, buf_valid_s, byp_valid_s, skip0_s, deq_buf_s;
  logic [2:0]            n_wr_s;
  logic [3:0]            we_s;
  logic [PTR_W-1:0]      widx_s [IB_SLOTS];
  logic [63:0]           slot_pc_s [IB_SLOTS];
  logic [IB_ENTRY_W-1:0] head_s;

  assign enq_fire_s  = ready_q & (|admin2ib_instr_valid) & ~redirect_flush;
  assign buf_valid_s = (count_q != '0) & ~redirect_flush;
`ifdef IB_BYPASS_EN
  assign byp_valid_s = enq_fire_s & (count_q == '0) & admin2ib_instr_valid[0];
`else
  assign byp_valid_s = 1'b0;
`endif
  assign skip0_s     = byp_valid_s & dec2ib_ready;
  assign deq_buf_s   = buf_valid_s & dec2ib_ready;

  ib_enq_ctrl #(.PTR_W(PTR_W)) u_enq_ctrl (
    .fire_i    (enq_fire_s),
    .skip0_i   (skip0_s),
    .valid_i   (admin2ib_instr_valid),
    .wr_ptr_i  (wr_ptr_q),
    .enq_pc_i  (ib_enq_pc),
    .n_wr_o    (n_wr_s),
    .we_o      (we_s),
    .widx_o    (widx_s),
    .slot_pc_o (slot_pc_s)
  );

  instr_buffer_chk u_chk (
    .clock_i   (clock),
    .reset_n_i (reset_n),
    .valid_i   (admin2ib_instr_valid)
  );

  // Pointer and occupancy next-state; flush overrides any same-cycle transfer.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PTR_W'(deq_buf_s);
      wr_ptr_d = wr_ptr_q + PTR_W'(n_wr_s);
      count_d  = count_q + (PTR_W+1)'(n_wr_s) - (PTR_W+1)'(deq_buf_s);
    end
  end

  // Control state; ready is precomputed from next occupancy so it comes straight off a flop.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ready_q  <= (count_d <= (PTR_W+1)'(DEPTH - 4));
    end
  end

  // Entry storage; data is deliberately left unreset.
  always_ff @(posedge clock) begin
    for (int i = 0; i < IB_SLOTS; i++) begin
      if (we_s[i]) begin
        mem_q[widx_s[i]] <= pack_entry(admin2ib_instr[32*i +: 32], slot_pc_s[i],
                                       admin2ib_predicttaken[i],
                                       admin2ib_predicttarget[32*i +: 32]);
      end
    end
  end

  // Head select: buffered entry first, bypassed slot 0 only when the buffer is empty.
  always_comb begin
    head_s = '0;
    if (buf_valid_s) begin
      head_s = mem_q[rd_ptr_q];
    end else if (byp_valid_s) begin
      head_s = pack_entry(admin2ib_instr[31:0], ib_enq_pc, admin2ib_predicttaken[0],
                          admin2ib_predicttarget[31:0]);
    end else begin
      head_s = '0;
    end
  end

  assign ib2admin_ready       = ready_q;
  assign ib2dec_valid         = buf_valid_s | byp_valid_s;
  assign ib2dec_instr         = head_s[IB_INSTR_LSB +: 32];
  assign ib2dec_pc            = head_s[IB_PC_LSB +: 64];
  assign ib2dec_predicttaken  = head_s[IB_TKN_BIT];
  assign ib2dec_predicttarget = head_s[IB_TGT_LSB +: 32];

endmodule

// File: tb/tb_instr_buffer.sv
// Scoreboard bench for instr_buffer: a queue model predicts ready, valid and head data each cycle.
module tb_instr_buffer;

  localparam int DEPTH = 16;
`ifdef IB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
    logic        taken;
    logic [31:0] tgt;
  } ent_t;

  logic         clock = 1'b0;
  logic         reset_n;
  logic [127:0] instr, target;
  logic [3:0]   vmask, taken;
  logic [63:0]  pc;
  logic         flush, dready;
  logic         ready, dvalid, dtaken;
  logic [31:0]  dinstr, dtgt;
  logic [63:0]  dpc;

  ent_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clock = ~clock;

  instr_buffer #(.DEPTH(DEPTH)) dut (
    .clock                  (clock),
    .reset_n                (reset_n),
    .admin2ib_instr         (instr),
    .admin2ib_instr_valid   (vmask),
    .admin2ib_predicttaken  (taken),
    .admin2ib_predicttarget (target),
    .ib_enq_pc              (pc),
    .ib2admin_ready         (ready),
    .redirect_flush         (flush),
    .ib2dec_valid           (dvalid),
    .dec2ib_ready           (dready),
    .ib2dec_instr           (dinstr),
    .ib2dec_pc              (dpc),
    .ib2dec_predicttaken    (dtaken),
    .ib2dec_predicttarget   (dtgt)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Called at the falling edge: predict this cycle's outputs, then advance the model.
  task automatic sample();
    int   pre;
    int   n;
    bit   fire, ev;
    ent_t e;
    pre  = sb.size();
    n    = $countones(vmask);
    fire = (pre <= DEPTH - 4) && (n != 0) && !flush;
    check_eq("ready", {63'd0, ready}, {63'd0, (pre <= DEPTH - 4)});
    if (fire) begin
      for (int i = 0; i < n; i++) begin
        e.instr = instr[32*i +: 32];
        e.pc    = pc + 64'(4 * i);
        e.taken = taken[i];
        e.tgt   = target[32*i +: 32];
        sb.push_back(e);
      end
    end
    ev = !flush && ((pre != 0) || (BYP && fire));
    check_eq("valid", {63'd0, dvalid}, {63'd0, ev});
    if (ev) begin
      e = sb[0];
      check_eq("instr", {32'd0, dinstr}, {32'd0, e.instr});
      check_eq("pc", dpc, e.pc);
      check_eq("taken", {63'd0, dtaken}, {63'd0, e.taken});
      check_eq("target", {32'd0, dtgt}, {32'd0, e.tgt});
      if (dready) void'(sb.pop_front());
    end else begin
      check_eq("idle_data", {dinstr, dtgt}, 64'd0);
      check_eq("idle_pc", dpc | {63'd0, dtaken}, 64'd0);
    end
    if (flush) sb.delete();
  endtask

  task automatic step(input logic [3:0] v, input logic [63:0] p, input bit fl, input bit dr);
    vmask  = v;
    pc     = p;
    flush  = fl;
    dready = dr;
    for (int i = 0; i < 4; i++) begin
      instr[32*i +: 32]  = $urandom;
      target[32*i +: 32] = $urandom;
    end
    taken = 4'($urandom);
    @(negedge clock);
    sample();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [3:0] masks [5];
    masks[0] = 4'b0000; masks[1] = 4'b0001; masks[2] = 4'b0011;
    masks[3] = 4'b0111; masks[4] = 4'b1111;
    reset_n = 1'b0;
    instr = '0; target = '0; vmask = 4'b0000; taken = 4'b0000;
    pc = 64'd0; flush = 1'b0; dready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_eq("rst_ready", {63'd0, ready}, 64'd1);
    check_eq("rst_valid", {63'd0, dvalid}, 64'd0);
    check_eq("rst_data", {dinstr, dtgt}, 64'd0);
    check_eq("rst_pc", dpc, 64'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // 4-wide group drained one per cycle
    step(4'b1111, 64'h0000_0000_8000_0000, 1'b0, 1'b1);
    repeat (5) step(4'b0000, 64'd0, 1'b0, 1'b1);

    // partial groups accumulate in order
    step(4'b0011, 64'h0000_0000_0000_1000, 1'b0, 1'b0);
    step(4'b0001, 64'h0000_0000_0000_2040, 1'b0, 1'b0);
    step(4'b0000, 64'd0, 1'b0, 1'b0);
    repeat (4) step(4'b0000, 64'd0, 1'b0, 1'b1);

    // fill to DEPTH, fifth group dropped, ready returns after drain
    for (int g = 0; g < 5; g++) step(4'b1111, 64'h4000 + 64'(16 * g), 1'b0, 1'b0);
    repeat (4) step(4'b0000, 64'd0, 1'b0, 1'b1);
    repeat (14) step(4'b0000, 64'd0, 1'b0, 1'b1);

    // pointer wrap: reach wr_ptr=14, drain, then write across the end
    step(4'b0000, 64'd0, 1'b1, 1'b0);
    for (int g = 0; g < 3; g++) step(4'b1111, 64'h9000 + 64'(16 * g), 1'b0, 1'b0);
    step(4'b0011, 64'h9100, 1'b0, 1'b0);
    repeat (14) step(4'b0000, 64'd0, 1'b0, 1'b1);
    step(4'b1111, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b0);
    repeat (5) step(4'b0000, 64'd0, 1'b0, 1'b1);

    // flush at count=5 with simultaneous enqueue/dequeue
    step(4'b1111, 64'hA000, 1'b0, 1'b0);
    step(4'b0001, 64'hA010, 1'b0, 1'b0);
    step(4'b1111, 64'hB000, 1'b1, 1'b1);
    repeat (3) step(4'b0000, 64'd0, 1'b0, 1'b1);

    // empty buffer, 3-wide enqueue with decode ready
    step(4'b0111, 64'hC000, 1'b0, 1'b1);
    repeat (4) step(4'b0000, 64'd0, 1'b0, 1'b1);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      step(masks[$urandom_range(0, 4)], {32'd0, $urandom} & ~64'd3,
           ($urandom_range(0, 31) == 0), ($urandom_range(0, 2) != 0));
    end
    repeat (20) step(4'b0000, 64'd0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
